// File: rtl/div_pkg.sv
// Shared state encoding and result-field layout for the iterative divider (iter_div).
package div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BYZERO = 3'd1,
    ON     = 3'd2,
    FIX    = 3'd3,
    END    = 3'd4
  } div_state_e;

  // result_o packs {remainder, quotient}. The quotient sits at bit 0.
  localparam int QUO_LSB = 0;

  // The remainder field starts at REM_LSB = WIDTH.
  function automatic int rem_lsb(input int width);
    return width;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift the dividend MSB into the partial
// remainder, trial-subtract the divisor, and keep the difference if it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;
  logic           q_bit;

  always_comb begin
    partial = {rem_i, quo_i[WIDTH-1]};
    diff    = partial - {1'b0, div_i};
    // rem_i < div_i always holds, so a clear borrow bit means partial >= divisor.
    q_bit   = ~diff[WIDTH];
    rem_o   = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/iter_div.sv
// Iterative signed/unsigned divider that produces one quotient bit per cycle.
// Define ITER_DIV_EARLY_OUT_EN to skip the iterations when |a| < |b|.
module iter_div
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int               REM_LSB = rem_lsb(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

`ifdef ITER_DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               div_zero_q, div_zero_d;
  logic               busy_q, busy_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;

  // Operand magnitudes. The most-negative value maps onto itself, and that is the
  // correct unsigned magnitude.
  always_comb begin
    a_neg = signed_i & op_a_i[WIDTH-1];
    b_neg = signed_i & op_b_i[WIDTH-1];
    a_mag = a_neg ? twos_neg(op_a_i) : op_a_i;
    b_mag = b_neg ? twos_neg(op_b_i) : op_b_i;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    // NOTE: every _d gets a hold default first, so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    div_d      = div_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    result_d   = result_q;
    ready_d    = ready_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          signed_d = signed_i;
          neg_a_d  = a_neg;
          neg_b_d  = b_neg;
          div_d    = b_mag;
          rem_d    = '0;
          quo_d    = a_mag;
          cnt_d    = '0;
          if (op_b_i == '0) begin
            state_d = BYZERO;
          end else if (EARLY_OUT && (a_mag < b_mag)) begin
            rem_d   = a_mag;
            quo_d   = '0;
            state_d = FIX;
          end else begin
            state_d = ON;
          end
        end
      end

      BYZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          // The remainder reports the dividend exactly as it was presented.
          result_d[REM_LSB +: WIDTH] = neg_a_q ? twos_neg(quo_q) : quo_q;
          result_d[QUO_LSB +: WIDTH] = '1;
          ready_d    = 1'b1;
          div_zero_d = 1'b1;
          state_d    = END;
        end
      end

      ON: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          result_d[REM_LSB +: WIDTH] = (signed_q && neg_a_q) ? twos_neg(rem_q) : rem_q;
          result_d[QUO_LSB +: WIDTH] = (signed_q && (neg_a_q != neg_b_q)) ? twos_neg(quo_q) : quo_q;
          ready_d = 1'b1;
          state_d = END;
        end
      end

      END: begin
        if (!start_i) begin
          result_d   = '0;
          ready_d    = 1'b0;
          div_zero_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make every flop sample the pre-edge values of the others.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign ready_o    = ready_q;
  assign result_o   = result_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_iter_div.sv
// Scoreboard bench for iter_div. It drives a WIDTH=32 and a WIDTH=8 instance.
// Latency is counted with the accepting edge as edge 1.
module tb_iter_div;

`ifdef ITER_DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef struct {
    logic [127:0] res;
    logic         dz;
    int           lat;
    int           acc;
  } exp_t;

  logic        clk, rst;
  logic        start32, start8, annul32, annul8, signed_s;
  logic [31:0] op_a, op_b;
  logic        busy32, rdy32, dz32, busy8, rdy8, dz8;
  logic [63:0] res32;
  logic [15:0] res8;
  int          cyc;
  int          checks, errors;
  exp_t        q32[$];
  exp_t        q8[$];

  iter_div #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .annul_i(annul32), .signed_i(signed_s),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy32), .ready_o(rdy32),
    .result_o(res32), .div_zero_o(dz32)
  );

  iter_div #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8), .signed_i(signed_s),
    .op_a_i(op_a[7:0]), .op_b_i(op_b[7:0]), .busy_o(busy8), .ready_o(rdy8),
    .result_o(res8), .div_zero_o(dz8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required earlier finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? rdy32 : rdy8;
  endfunction

  function automatic logic busy(input int d);
    return (d == 0) ? busy32 : busy8;
  endfunction

  function automatic logic [127:0] cur_res(input int d);
    return (d == 0) ? 128'(res32) : 128'(res8);
  endfunction

  // Concatenates busy, ready, div_zero and result into one value, so the
  // "all outputs 0" checks take a single comparison.
  function automatic logic [127:0] outs(input int d);
    if (d == 0) return 128'({busy32, rdy32, dz32, res32});
    else        return 128'({busy8, rdy8, dz8, res8});
  endfunction

  function automatic exp_t mk(input logic [127:0] res, input logic dz, input int lat);
    exp_t e;
    e.res = res; e.dz = dz; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Reference model. It uses plain integer division, which truncates toward zero,
  // so the remainder takes the sign of the dividend.
  function automatic exp_t model(input int w, input bit sgn, input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    longint      sa, sb, q, r, ma, mb;
    logic [63:0] mask, qb, rb;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a & mask);
    sb = longint'(b & mask);
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    e.dz  = 1'b0;
    e.acc = 0;
    if (sb == 0) begin
      q = longint'(mask);
      r = longint'(a & mask);
      e.dz  = 1'b1;
      e.lat = 2;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      e.lat = (EARLY_OUT && (ma < mb)) ? 2 : w + 2;
    end
    qb = 64'(q) & mask;
    rb = 64'(r) & mask;
    e.res = 128'((rb << w) | qb);
    return e;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) start32 = v; else start8 = v;
  endtask

  // Called at the negedge right after the accepting edge. It queues the
  // expectation, scrambles the operands, then waits for the result and retires it.
  task automatic complete(input int d, input exp_t e);
    int n;
    e.acc = cyc;
    if (d == 0) q32.push_back(e); else q8.push_back(e);
    check("busy_after_accept", busy(d), 1);
    op_a = $urandom;
    op_b = $urandom;
    signed_s = 1'($urandom_range(0, 1));
    n = 0;
    while (!rdy(d) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_seen", rdy(d), 1);
    @(negedge clk);
    check("ready_held", rdy(d), 1);
    check("result_held", cur_res(d), e.res);
    set_start(d, 1'b0);
    @(negedge clk);
    check("drop_clears", outs(d), 0);
  endtask

  task automatic issue(input int d, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    @(negedge clk);
    signed_s = sgn;
    op_a = a;
    op_b = b;
    set_start(d, 1'b1);
    @(negedge clk);
    complete(d, e);
  endtask

  task automatic rand_issue(input int d);
    logic [31:0] a, b;
    bit          sgn;
    int          w;
    w   = (d == 0) ? 32 : 8;
    a   = $urandom;
    b   = $urandom;
    sgn = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0: b = 0;
      1: b = $urandom_range(1, 9);
      2: a = $urandom_range(0, 5);
      3: b = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
      default: ;
    endcase
    issue(d, sgn, a, b, model(w, sgn, 64'(a), 64'(b)));
  endtask

  // Monitor: every rising ready pops one expectation and checks the value and latency.
  initial begin
    logic [1:0] prev;
    exp_t       e;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rdy(d) && !prev[d]) begin
          if ((d == 0 && q32.size() == 0) || (d == 1 && q8.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready dut%0d: got ready=1, expected no result (cycle %0d)", d, cyc);
          end else begin
            e = (d == 0) ? q32.pop_front() : q8.pop_front();
            check("result", cur_res(d), e.res);
            check("div_zero", (d == 0) ? dz32 : dz8, e.dz);
            check("latency", 128'(cyc - e.acc + 1), 128'(e.lat));
          end
        end
        prev[d] = rdy(d);
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start32 = 0; start8 = 0; annul32 = 0; annul8 = 0;
    signed_s = 0; op_a = 0; op_b = 0;
    repeat (3) @(negedge clk);
    check("reset_dut32", outs(0), 0);
    check("reset_dut8", outs(1), 0);
    rst = 1'b0;

    issue(0, 0, 32'd100, 32'd7, mk(128'({32'd2, 32'd14}), 0, 34));
    issue(0, 1, 32'hFFFF_FFF9, 32'd2, mk(128'({32'hFFFF_FFFF, 32'hFFFF_FFFD}), 0, 34));
    issue(0, 1, 32'd7, 32'hFFFF_FFFE, mk(128'({32'd1, 32'hFFFF_FFFD}), 0, 34));
    issue(0, 0, 32'd5, 32'd0, mk(128'({32'd5, 32'hFFFF_FFFF}), 1, 2));

    // Annul the division in its 10th ON cycle, then check that start is ignored while annul is held.
    @(negedge clk);
    signed_s = 0; op_a = 32'd100; op_b = 32'd7; start32 = 1'b1;
    repeat (10) @(negedge clk);
    annul32 = 1'b1;
    @(negedge clk);
    check("annul_to_idle", outs(0), 0);
    @(negedge clk);
    check("annul_blocks_start", outs(0), 0);
    annul32 = 1'b0;
    @(negedge clk);
    complete(0, mk(128'({32'd2, 32'd14}), 0, 34));

    // Assert reset in the middle of the iterations.
    @(negedge clk);
    signed_s = 0; op_a = 32'd1000; op_b = 32'd3; start32 = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_mid_on", busy32, 1);
    rst = 1'b1; start32 = 1'b0;
    @(negedge clk);
    check("reset_mid_on", outs(0), 0);
    rst = 1'b0;

    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, mk(128'({32'd0, 32'h8000_0000}), 0, 34));

    issue(1, 0, 32'd3, 32'd9, mk(128'({8'd3, 8'd0}), 0, EARLY_OUT ? 2 : 10));
    issue(1, 1, 32'h80, 32'hFF, mk(128'({8'd0, 8'h80}), 0, 10));
    issue(1, 1, 32'hFB, 32'd0, mk(128'({8'hFB, 8'hFF}), 1, 2));

    repeat (60) rand_issue(1);
    repeat (25) rand_issue(0);

    repeat (4) @(negedge clk);
    check("queue_drained", 128'(q32.size() + q8.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal 8..64, even).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), iteration counter width (derived; not overridden).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request; held high until result consumed.
REQ-006 SHALL have port annul_i  input  1  cancel in-flight division (pipeline flush).
REQ-007 SHALL have port signed_i  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port op_a_i  input  WIDTH  dividend.
REQ-009 SHALL have port op_b_i  input  WIDTH  divisor.
REQ-010 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-011 SHALL have port ready_o  output  1  result valid.
REQ-012 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}.
REQ-013 SHALL have port div_zero_o  output  1  result came from zero divisor; valid with ready_o.

Function
REQ-014 SHALL implement FSM IDLE, BYZERO, ON, FIX, END; encoding from package.
REQ-015 SHALL, in IDLE with start_i=1 and annul_i=0, capture signed_i, operand signs and magnitudes (negated if signed_i and MSB set) into internal registers; inputs need not stay stable afterwards.
REQ-016 SHALL go IDLE->BYZERO when op_b_i=0, else IDLE->ON with counter cleared.
REQ-017 SHALL perform one restoring radix-2 step per cycle in ON for exactly WIDTH cycles, then go to FIX.
REQ-018 SHALL in FIX negate quotient when captured signs differ (signed only), negate remainder when dividend negative (signed only), load result_o, assert ready_o, go to END.
REQ-019 SHALL give ready_o exactly WIDTH+2 rising edges after the edge that accepted start_i (normal path).
REQ-020 SHALL from BYZERO go to END next edge with quotient all-ones, remainder = op_a captured value, div_zero_o=1, ready_o=1 (latency 2 edges).
REQ-021 SHALL hold result_o, ready_o, div_zero_o stable in END while start_i=1; on start_i=0 go IDLE and clear all three to 0 on that edge.
REQ-022 SHALL on annul_i=1 in BYZERO, ON or FIX go IDLE next edge, ready_o=0, result_o unchanged at 0; annul_i in END is ignored.
REQ-023 SHALL ignore start_i with annul_i=1 in IDLE (stays IDLE).
REQ-024 SHALL produce quotient = most-negative, remainder 0 for signed most-negative / -1 (no trap, no flag).
REQ-025 SHALL keep result_o=0 and ready_o=0 in all states except END.

Reset
REQ-026 SHALL, with rst=1 at an edge, force IDLE, busy_o=0, ready_o=0, div_zero_o=0, result_o=0, counter 0, regardless of state (including mid-ON); rst dominates annul_i and start_i.

Configuration
REQ-027 SHALL honour macro ITER_DIV_EARLY_OUT_EN: when defined, IDLE with |a| < |b| (nonzero b) goes directly to FIX with quotient 0, remainder = |a|, ready_o 2 edges after accept.
REQ-028 SHALL, without ITER_DIV_EARLY_OUT_EN, always take the full WIDTH-cycle ON path; results identical in both builds.

Structure
REQ-029 SHALL place state enum, result field offsets (REM_LSB = WIDTH) in shared package div_pkg.
REQ-030 SHALL isolate one combinational restoring step (trial subtract WIDTH+1 bits, shift, quotient bit) in sub-module div_step, parametrised by WIDTH.

Verification
REQ-031 SHALL cover unsigned 100/7, WIDTH=32 -> ready_o at edge 34, result_o={32'd2,32'd14}, div_zero_o=0.
REQ-032 SHALL cover signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-033 SHALL cover 5/0 -> ready_o at edge 2, quotient 0xFFFFFFFF, remainder 5, div_zero_o=1; start_i dropped -> all outputs 0 next edge.
REQ-034 SHALL cover annul_i at ON cycle 10 -> IDLE next edge, ready_o never asserts; new start accepted the following cycle.
REQ-035 SHALL cover rst asserted mid-ON -> all outputs 0 next edge; signed 0x80000000/-1 -> quotient 0x80000000, remainder 0.
REQ-036 SHALL cover WIDTH=8 with ITER_DIV_EARLY_OUT_EN: 3/9 -> ready_o at edge 2, {8'd3,8'd0}; random regression vs golden model both builds.
